lcd_ber_display: RTL and testbench
==================================

// Module: lcd_ber_display
// PURPOSE
//  Measures bit errors between sent_data and recv_data over a fixed window of WIN_BITS bits.
//  At each window close, converts the error count to NDIGITS decimal ASCII digits.
//  Writes those digits to the character LCD through the lcd_control write port (lcd_we/lcd_busy).
//  Parametrised successor of the fixed-value BER display top; sits between the demod/compare path and lcd_control.
// PARAMETERS
//  DATA_W    8          width of sent_data/recv_data
//  WIN_BITS  1000000    bits per measurement window (display = errors per WIN_BITS bits)
//  NDIGITS   7          decimal digits shown; 1..10
//  LCD_ROW   1'b1       LCD row written
//  LCD_COL0  4'd0       column of most-significant digit; LCD_COL0+NDIGITS-1 <= 15
// PORTS
//  CLK             in   1         system clock
//  RST             in   1         synchronous reset, active-high
//  valid_i         in   1         sent_data/recv_data/number_of_bits valid this cycle
//  sent_data       in   DATA_W    reference bits
//  recv_data       in   DATA_W    received bits
//  number_of_bits  in   CW        valid LSBs this beat; CW=$clog2(DATA_W+1); values >DATA_W clamp to DATA_W
//  start           in   1         manual refresh: close current window early
//  lcd_busy        in   1         lcd_control busy
//  lcd_row         out  1         write row
//  lcd_col         out  4         write column
//  lcd_char        out  8         ASCII character
//  lcd_we          out  1         one-cycle write strobe
//  update          out  1         one-cycle pulse after last digit of a refresh is written
//  err_latched     out  ERR_W     error count of last closed window; ERR_W=$clog2(WIN_BITS+DATA_W+1)
// BEHAVIOUR
//  Reset: all outputs 0 (lcd_row=LCD_ROW, lcd_char=8'h20 permitted); accumulators, pending flag and FSM cleared. Reset mid-refresh aborts it with no further lcd_we.
//  Accumulate: on valid_i, err_acc += popcount((sent^recv) & mask(number_of_bits)); bit_acc += clamped number_of_bits. Pipeline is 1 register stage.
//  Window close: when bit_acc+nb >= WIN_BITS, or start=1 (including bit_acc=0 -> count 0).
//   - The crossing beat counts entirely in the closing window.
//   - err_latched <= total in the next cycle; accumulators restart at 0; bits are not carried over.
//   - If a close and valid_i coincide, the beat belongs to the closing window.
//  Pending: one-deep. A close while the FSM is not IDLE sets pend and overwrites the snapshot (newest wins).
//  FSM: IDLE -> CONV -> WAITB -> WRITE -> GAP -> (WAITB | DONE) -> IDLE.
//   - IDLE: on a snapshot or pend, clear pend and load the converter.
//   - CONV: sequential double-dabble over ERR_W cycles (+1 to latch). Values > 10^NDIGITS-1 saturate to all '9'.
//   - WAITB: wait until lcd_busy=0.
//   - WRITE: lcd_we=1 for exactly one cycle; lcd_col=LCD_COL0+i; lcd_char=8'h30+digit, MSD first.
//     Leading zeros become 8'h20 (space); the LSD is always a digit.
//   - GAP: one idle cycle so lcd_control can raise busy; lcd_we never issues back-to-back.
//   - DONE: update=1 for one cycle.
//  lcd_row/col/char are held stable from WRITE until the next WRITE.
//  lcd_busy high in any state other than WAITB has no effect.
//  start while not IDLE: closes the window, goes to pend; the in-flight refresh is not aborted.
// STRUCTURE
//  Package lcd_ber_pkg:
//   - FSM state enum (IDLE, CONV, WAITB, WRITE, GAP, DONE).
//   - ASCII_0=8'h30, ASCII_SP=8'h20.
//   - Function clog2-based ERR_W helper.
//  Sub-module bin2bcd_seq: parametrised by BIN_W and NDIGITS.
//   - Interface: load/bin_i in, done/bcd_o out; saturates.
//  Top holds the popcount/accumulator, window/pend logic and the write FSM.
// TESTING
//  1. WIN_BITS=64, DATA_W=8, 8 beats sent=recv=8'hA5, nb=8 -> LCD writes "      0"; update once; err_latched=0.
//  2. Same, each beat recv=sent^8'h01 -> err_latched=8; LCD "      8" at cols 0..6, row 1.
//  3. nb=3, sent^recv=8'hFF -> only 3 errors per beat counted; nb=15 clamps to 8.
//  4. NDIGITS=2, count 123 -> "99" written (saturation).
//  5. Hold lcd_busy=1 for 20 cycles before each write:
//     - no lcd_we while busy; exactly NDIGITS strobes; no back-to-back lcd_we.
//  6. start pulse mid-refresh, then RST mid-refresh:
//     - second refresh follows the first with the newer value;
//     - after RST, lcd_we=0 and err_latched=0 next cycle.

Source files
------------

// File: rtl/lcd_ber_pkg.sv
// lcd_ber_pkg: FSM states, ASCII codes and width helpers shared by the BER display
package lcd_ber_pkg;
   typedef enum logic [2:0] {IDLE, CONV, WAITB, WRITE, GAP, DONE} state_t;
   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_SP = 8'h20;
   function automatic int err_width(input int win_bits, input int data_w);
      return $clog2(win_bits + data_w + 1);
   endfunction
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p;
   endfunction
endpackage

// File: rtl/lcd_ber_display_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, saturating to all nines
module bin2bcd_seq
   import lcd_ber_pkg::*;
#(
   parameter int BIN_W = 20,
   parameter int NDIGITS = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [BIN_W-1:0]       bin_i,
   output logic                   done,
   output logic [4*NDIGITS-1:0]   bcd_o
);
   localparam logic [63:0] MAXV = pow10(NDIGITS) - 64'd1;
   localparam int CNW = $clog2(BIN_W + 1);
   logic [BIN_W-1:0] bin;
   logic [4*NDIGITS-1:0] bcd, adj;
   logic [CNW-1:0] cnt;
   logic busy, sat;
   always_comb begin
      adj = bcd;
      for (int k = 0; k < NDIGITS; k++)
         adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bin <= '0;
         bcd <= '0;
         bcd_o <= '0;
         cnt <= '0;
         busy <= 1'b0;
         sat <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            bin <= bin_i;
            bcd <= '0;
            cnt <= CNW'(BIN_W);
            busy <= 1'b1;
            sat <= 64'(bin_i) > MAXV;
         end else if (busy && cnt != '0) begin
            bcd <= {adj[4*NDIGITS-2:0], bin[BIN_W-1]};
            bin <= bin << 1;
            cnt <= cnt - CNW'(1);
         end else if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
            bcd_o <= sat ? {NDIGITS{4'd9}} : bcd;
         end
      end
   end
endmodule

// File: rtl/lcd_ber_display.sv
// lcd_ber_display: windowed bit-error counter that writes the count to a character LCD
module lcd_ber_display
   import lcd_ber_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int WIN_BITS = 1000000,
   parameter int NDIGITS = 7,
   parameter logic LCD_ROW = 1'b1,
   parameter logic [3:0] LCD_COL0 = 4'd0,
   localparam int CW = $clog2(DATA_W + 1),
   localparam int ERR_W = err_width(WIN_BITS, DATA_W)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] sent_data,
   input  logic [DATA_W-1:0] recv_data,
   input  logic [CW-1:0]     number_of_bits,
   input  logic              start,
   input  logic              lcd_busy,
   output logic              lcd_row,
   output logic [3:0]        lcd_col,
   output logic [7:0]        lcd_char,
   output logic              lcd_we,
   output logic              update,
   output logic [ERR_W-1:0]  err_latched
);
   localparam int IW = $clog2(NDIGITS + 1);
   localparam logic [ERR_W-1:0] WIN = ERR_W'(WIN_BITS);
   logic [CW-1:0] nbc, pop;
   logic [DATA_W-1:0] diff;
   logic [ERR_W-1:0] err_acc, bit_acc, err_sum, bit_sum;
   logic close, snap, pend, go, conv_done, blank, last, lead;
   logic [4*NDIGITS-1:0] bcd, digs;
   logic [IW-1:0] idx;
   logic [3:0] msd;
   state_t state, state_n;
   assign lcd_row = LCD_ROW;
   always_comb begin
      nbc = (number_of_bits > CW'(DATA_W)) ? CW'(DATA_W) : number_of_bits;
      diff = (sent_data ^ recv_data) & ~({DATA_W{1'b1}} << nbc);
      pop = '0;
      for (int k = 0; k < DATA_W; k++) pop = pop + CW'(diff[k]);
      err_sum = err_acc + (valid_i ? ERR_W'(pop) : '0);
      bit_sum = bit_acc + (valid_i ? ERR_W'(nbc) : '0);
      close = start | (bit_sum >= WIN);
   end
   // The closing beat is folded into the latched total; the next window starts empty.
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_acc <= '0;
         bit_acc <= '0;
         err_latched <= '0;
         snap <= 1'b0;
         pend <= 1'b0;
      end else begin
         snap <= close;
         pend <= (state == IDLE) ? 1'b0 : pend | snap;
         err_acc <= close ? '0 : err_sum;
         bit_acc <= close ? '0 : bit_sum;
         if (close) err_latched <= err_sum;
      end
   end
   assign go = (state == IDLE) && (snap || pend);
   bin2bcd_seq #(.BIN_W(ERR_W), .NDIGITS(NDIGITS)) conv (
      .clk(CLK), .rst(RST), .load(go), .bin_i(err_latched), .done(conv_done), .bcd_o(bcd)
   );
   assign msd = digs[4*NDIGITS-1 -: 4];
   assign last = idx == IW'(NDIGITS - 1);
   assign blank = lead && msd == 4'd0 && !last;
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      lcd_we = 1'b0;
      update = 1'b0;
      case (state)
         IDLE:  state_n = go ? CONV : IDLE;
         CONV:  state_n = conv_done ? WAITB : CONV;
         WAITB: state_n = lcd_busy ? WAITB : WRITE;
         WRITE: begin
            lcd_we = 1'b1;
            state_n = GAP;
         end
         GAP:   state_n = last ? DONE : WAITB;
         DONE:  begin
            update = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // Column/char are loaded on leaving WAITB so they are valid during WRITE and held afterwards.
   always_ff @(posedge CLK) begin
      if (RST) begin
         idx <= '0;
         digs <= '0;
         lead <= 1'b0;
         lcd_col <= '0;
         lcd_char <= '0;
      end else begin
         if (go) begin
            idx <= '0;
            lead <= 1'b1;
         end
         if (state == CONV && conv_done) digs <= bcd;
         if (state == WAITB && !lcd_busy) begin
            lcd_col <= LCD_COL0 + 4'(idx);
            lcd_char <= blank ? ASCII_SP : ASCII_0 + {4'd0, msd};
            lead <= blank;
         end
         if (state == WRITE) digs <= digs << 4;
         if (state == GAP && !last) idx <= idx + IW'(1);
      end
   end
endmodule

// File: tb/tb_lcd_ber_display.sv
// tb_lcd_ber_display: directed vector and sequence checks for the BER LCD display
module tb_lcd_ber_display;
   logic clk = 1'b0, rst = 1'b1, valid = 1'b0, start = 1'b0, busy = 1'b0;
   logic [7:0] sent = '0, recv = '0;
   logic [3:0] nb = '0;
   logic row1, we1, upd1, row2, we2, upd2;
   logic [3:0] col1, col2;
   logic [7:0] char1, char2;
   logic [6:0] err1;
   logic [8:0] err2;
   int checks = 0, errors = 0;
   logic [11:0] q1[$], q2[$];
   int u1 = 0, u2 = 0;
   bit b2b = 0, rowbad = 0, we_prev = 0;

   typedef struct {
      string name;
      logic [7:0] s, r;
      logic [3:0] n;
      int beats;
      int exp_err;
      string exp_str;
   } vec_t;
   vec_t tab[5];

   always #5 clk = ~clk;

   lcd_ber_display #(.DATA_W(8), .WIN_BITS(64), .NDIGITS(7), .LCD_ROW(1'b1), .LCD_COL0(4'd0)) dut (
      .CLK(clk), .RST(rst), .valid_i(valid), .sent_data(sent), .recv_data(recv),
      .number_of_bits(nb), .start(start), .lcd_busy(busy), .lcd_row(row1), .lcd_col(col1),
      .lcd_char(char1), .lcd_we(we1), .update(upd1), .err_latched(err1)
   );
   lcd_ber_display #(.DATA_W(8), .WIN_BITS(256), .NDIGITS(2), .LCD_ROW(1'b1), .LCD_COL0(4'd0)) dut2 (
      .CLK(clk), .RST(rst), .valid_i(valid), .sent_data(sent), .recv_data(recv),
      .number_of_bits(nb), .start(start), .lcd_busy(busy), .lcd_row(row2), .lcd_col(col2),
      .lcd_char(char2), .lcd_we(we2), .update(upd2), .err_latched(err2)
   );

   always @(posedge clk) begin
      #1;
      if (we1) begin
         q1.push_back({col1, char1});
         if (we_prev) b2b = 1;
         if (row1 !== 1'b1) rowbad = 1;
      end
      we_prev = we1;
      if (upd1) u1++;
      if (we2) q2.push_back({col2, char2});
      if (upd2) u2++;
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chks(input string name, input string got, input string exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
      end
   endtask

   function automatic string text(input int which);
      string s = "";
      int n = (which == 1) ? q1.size() : q2.size();
      for (int k = 0; k < n; k++) s = $sformatf("%s%c", s, (which == 1) ? q1[k][7:0] : q2[k][7:0]);
      return s;
   endfunction

   function automatic bit cols_ok(input int which, input int nd);
      int n = (which == 1) ? q1.size() : q2.size();
      for (int k = 0; k < n; k++)
         if (((which == 1) ? q1[k][11:8] : q2[k][11:8]) != 4'(k % nd)) return 0;
      return 1;
   endfunction

   task automatic clear();
      q1.delete();
      q2.delete();
      u1 = 0;
      u2 = 0;
      b2b = 0;
   endtask

   task automatic send(input logic [7:0] s, input logic [7:0] r, input logic [3:0] n, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         valid = 1;
         sent = s;
         recv = r;
         nb = n;
         @(negedge clk);
      end
      valid = 0;
   endtask

   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_u(input string name, input int which, input int n);
      int c = 0;
      while (((which == 1) ? u1 : u2) < n && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk(name, ((which == 1) ? u1 : u2) >= n, 1);
   endtask

   task automatic wait_we(input string name);
      int c = 0;
      while (!we1 && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk(name, we1, 1);
   endtask

   initial begin
      int bw;
      tab[0] = '{"clean", 8'hA5, 8'hA5, 4'd8, 8, 0, "      0"};
      tab[1] = '{"one_bit", 8'hA5, 8'hA4, 4'd8, 8, 8, "      8"};
      tab[2] = '{"nb3_mask", 8'h00, 8'hFF, 4'd3, 22, 66, "     66"};
      tab[3] = '{"nb15_clamp", 8'h00, 8'hFF, 4'd15, 8, 64, "     64"};
      tab[4] = '{"nb5_cross", 8'hA5, 8'h5A, 4'd5, 13, 65, "     65"};
      repeat (3) @(negedge clk);
      chk("reset_we", we1, 0);
      chk("reset_update", upd1, 0);
      chk("reset_err", err1, 0);
      chk("reset_col", col1, 0);
      rst = 0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         clear();
         send(tab[i].s, tab[i].r, tab[i].n, tab[i].beats);
         wait_u({tab[i].name, "_update_seen"}, 1, 1);
         repeat (5) @(negedge clk);
         chk({tab[i].name, "_err"}, err1, tab[i].exp_err);
         chks({tab[i].name, "_text"}, text(1), tab[i].exp_str);
         chk({tab[i].name, "_cols"}, cols_ok(1, 7), 1);
         chk({tab[i].name, "_updates"}, u1, 1);
      end
      chk("row_always_1", rowbad, 0);

      clear();
      bw = 0;
      busy = 1;
      send(8'hA5, 8'hA4, 4'd8, 8);
      for (int d = 0; d < 7; d++) begin
         repeat (20) begin
            @(negedge clk);
            if (we1) bw++;
         end
         busy = 0;
         wait_we($sformatf("busy_write_%0d", d));
         busy = 1;
      end
      busy = 0;
      wait_u("busy_update_seen", 1, 1);
      repeat (3) @(negedge clk);
      chk("busy_we_while_busy", bw, 0);
      chk("busy_strobes", q1.size(), 7);
      chks("busy_text", text(1), "      8");
      chk("busy_back_to_back", b2b, 0);

      clear();
      send(8'hA5, 8'hA4, 4'd8, 8);
      wait_we("pend_first_write");
      send(8'h00, 8'hFF, 4'd8, 2);
      pulse_start();
      wait_u("pend_two_updates", 1, 2);
      repeat (3) @(negedge clk);
      chks("pend_text", text(1), "      8     16");
      chk("pend_err", err1, 16);
      chk("pend_updates", u1, 2);
      chk("pend_back_to_back", b2b, 0);

      clear();
      send(8'h00, 8'h0F, 4'd8, 1);
      pulse_start();
      wait_we("rst_first_write");
      rst = 1;
      @(negedge clk);
      chk("rst_we", we1, 0);
      chk("rst_err", err1, 0);
      rst = 0;
      repeat (40) @(negedge clk);
      chk("rst_no_more_writes", q1.size(), 1);
      chk("rst_no_update", u1, 0);

      clear();
      send(8'h00, 8'hFF, 4'd8, 15);
      send(8'h00, 8'hFF, 4'd3, 1);
      pulse_start();
      wait_u("sat_update_seen", 2, 1);
      repeat (3) @(negedge clk);
      chk("sat_err", err2, 123);
      chks("sat_text", text(2), "99");
      chk("sat_cols", cols_ok(2, 2), 1);
      chk("sat_updates", u2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
